// File: rtl/cnn_conv_bias_relu_pkg.sv
// rtl/cnn_conv_bias_relu_pkg.sv - shared conv constants, FSM encoding and counter sizing helpers
package cnn_conv_bias_relu_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int IMAGE_WIDTH_DEFAULT  = 8;
    localparam int IMAGE_HEIGHT_DEFAULT = 8;
    localparam int IMAGE_SIZE_DEFAULT   = IMAGE_WIDTH_DEFAULT * IMAGE_HEIGHT_DEFAULT;

    function automatic int image_size(input int width, input int height);
        return width * height;
    endfunction

    // Counters never narrower than one bit, even for a single channel.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_sat_add.sv
// rtl/cnn_sat_add.sv - combinational signed add with saturation to the operand width
module cnn_sat_add #(
    parameter int DATA_WIDTH = 16
) (
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [DATA_WIDTH-1:0] sum
);

    localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH:0] wide;

    assign wide = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};

    // Overflow shows up as disagreement between the two top bits of the wide sum.
    always_comb begin
        sum = wide[DATA_WIDTH-1:0];
        if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1]) begin
            sum = wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/cnn_conv_bias_relu.sv
// rtl/cnn_conv_bias_relu.sv - per-channel bias add, saturate and optional ReLU (CNN_CONV_BIAS_RELU_EN)
module cnn_conv_bias_relu
    import cnn_conv_bias_relu_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int IMAGE_WIDTH     = IMAGE_WIDTH_DEFAULT,
    parameter int IMAGE_HEIGHT    = IMAGE_HEIGHT_DEFAULT,
    parameter int CHANNEL_NUM_OUT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    input  logic                  valid_bias_in,
    input  logic [DATA_WIDTH-1:0] bias_in,
    input  logic                  stride2,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  bias_loaded,
    output logic                  drop_err
);

    localparam int IMAGE_SIZE = image_size(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int PIX_W      = cnt_width(IMAGE_SIZE);
    localparam int CH_W       = cnt_width(CHANNEL_NUM_OUT);

    localparam logic [PIX_W-1:0] LAST_FULL = PIX_W'(IMAGE_SIZE - 1);
    localparam logic [PIX_W-1:0] LAST_QTR  = PIX_W'(IMAGE_SIZE / 4 - 1);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(CHANNEL_NUM_OUT - 1);

    state_t                         state;
    logic [CH_W-1:0]                bias_cnt;
    logic [CH_W-1:0]                ch_cnt;
    logic [PIX_W-1:0]               pix_cnt;
    logic                           stride_q;
    logic signed [DATA_WIDTH-1:0]   bias_mem [CHANNEL_NUM_OUT];

    logic                           s1_valid;
    logic signed [DATA_WIDTH-1:0]   s1_pxl;
    logic signed [DATA_WIDTH-1:0]   s1_bias;
    logic signed [DATA_WIDTH-1:0]   sat_sum;
    logic signed [DATA_WIDTH-1:0]   s2_next;

    logic accept;
    logic frame_start;
    logic stride_eff;
    logic pix_last;

    assign accept      = (state == RUN) && valid_in;
    assign frame_start = (pix_cnt == '0) && (ch_cnt == '0);
    // The frame's stride is taken live on its first pixel and held afterwards.
    assign stride_eff  = frame_start ? stride2 : stride_q;
    assign pix_last    = (pix_cnt == (stride_eff ? LAST_QTR : LAST_FULL));

    // Bias storage is deliberately left out of reset; bias_loaded gates its use.
    always_ff @(posedge clk) begin
        if (!reset && (state == LOAD) && valid_bias_in) begin
            bias_mem[bias_cnt] <= bias_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= LOAD;
            bias_cnt    <= '0;
            ch_cnt      <= '0;
            pix_cnt     <= '0;
            stride_q    <= 1'b0;
            bias_loaded <= 1'b0;
            drop_err    <= 1'b0;
            s1_valid    <= 1'b0;
            s1_pxl      <= '0;
            s1_bias     <= '0;
            valid_out   <= 1'b0;
            pxl_out     <= '0;
        end else begin
            drop_err <= (state == LOAD) && valid_in;

            case (state)
                LOAD: begin
                    if (valid_bias_in) begin
                        if (bias_cnt == LAST_CH) begin
                            state       <= RUN;
                            bias_loaded <= 1'b1;
                            bias_cnt    <= '0;
                        end else begin
                            bias_cnt <= bias_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (valid_in) begin
                        if (frame_start) begin
                            stride_q <= stride2;
                        end
                        if (pix_last) begin
                            pix_cnt <= '0;
                            ch_cnt  <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase

            s1_valid <= accept;
            if (accept) begin
                s1_pxl  <= pxl_in;
                s1_bias <= bias_mem[ch_cnt];
            end

            valid_out <= s1_valid;
            if (s1_valid) begin
                pxl_out <= s2_next;
            end
        end
    end

    cnn_sat_add #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sat_add (
        .a  (s1_pxl),
        .b  (s1_bias),
        .sum(sat_sum)
    );

`ifdef CNN_CONV_BIAS_RELU_EN
    assign s2_next = sat_sum[DATA_WIDTH-1] ? '0 : sat_sum;
`else
    assign s2_next = sat_sum;
`endif

endmodule

// File: tb/tb_cnn_conv_bias_relu.sv
// tb/tb_cnn_conv_bias_relu.sv - scoreboard bench for cnn_conv_bias_relu
module tb_cnn_conv_bias_relu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [15:0] pxl_in = '0;
    logic        valid_bias_in = 1'b0;
    logic [15:0] bias_in = '0;
    logic        stride2 = 1'b0;
    logic [15:0] pxl_out;
    logic        valid_out;
    logic        bias_loaded;
    logic        drop_err;

    int cyc = 0;
    int total = 0;
    int passed = 0;

    typedef struct {
        int val;
        int cyc;
    } exp_t;
    exp_t sbq[$];

    int mbias[2];
    int mbcnt = 0;
    bit mloaded = 0;
    int fidx = 0;
    int fn = 64;

    cnn_conv_bias_relu #(
        .DATA_WIDTH(16),
        .IMAGE_WIDTH(8),
        .IMAGE_HEIGHT(8),
        .CHANNEL_NUM_OUT(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .valid_in(valid_in),
        .pxl_in(pxl_in),
        .valid_bias_in(valid_bias_in),
        .bias_in(bias_in),
        .stride2(stride2),
        .pxl_out(pxl_out),
        .valid_out(valid_out),
        .bias_loaded(bias_loaded),
        .drop_err(drop_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ref_out(input int p, input int b);
        int s;
        s = p + b;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef CNN_CONV_BIAS_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic int rand16();
        logic [15:0] r;
        r = 16'($urandom);
        return int'($signed(r));
    endfunction

    // Model: each frame is CH blocks of fn pixels; fn fixed by stride2 on the frame's first pixel.
    task automatic drive(input bit vin, input int p, input bit vb, input int b, input bit s2);
        @(posedge clk);
        #1;
        valid_in      = vin;
        pxl_in        = 16'(p);
        valid_bias_in = vb;
        bias_in       = 16'(b);
        stride2       = s2;
        if (vin && mloaded) begin
            if (fidx == 0) fn = s2 ? 16 : 64;
            sbq.push_back('{ref_out(p, mbias[fidx / fn]), cyc});
            fidx++;
            if (fidx == fn * 2) fidx = 0;
        end
        if (vb && !mloaded) begin
            mbias[mbcnt] = b;
            mbcnt++;
            if (mbcnt == 2) mloaded = 1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        valid_in = 1'b0;
        valid_bias_in = 1'b0;
        while (sbq.size() > 0 && sbq[sbq.size()-1].cyc >= cyc - 1) sbq.pop_back();
        mloaded = 0;
        mbcnt = 0;
        fidx = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_valid_out", int'(valid_out), 0);
        check("rst_pxl_out", int'(pxl_out), 0);
        check("rst_bias_loaded", int'(bias_loaded), 0);
        check("rst_drop_err", int'(drop_err), 0);
    endtask

    task automatic load_bias(input int b0, input int b1);
        drive(0, 0, 1, b0, 0);
        drive(0, 0, 1, b1, 0);
        drive(0, 0, 0, 0, 0);
        check("bias_loaded", int'(bias_loaded), 1);
    endtask

    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                $display("FAIL unexpected_valid_out: got pxl_out %0d expected no output (cycle %0d)",
                         $signed(pxl_out), cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("pxl_out", int'($signed(pxl_out)), e.val);
                check("latency", cyc - e.cyc, 2);
            end
        end else if (sbq.size() > 0 && sbq[0].cyc + 2 <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            total++;
            $display("FAIL missing_valid_out: got none expected %0d (cycle %0d)", e.val, cyc);
        end
    end

    initial begin
        do_reset();

        // Pixel during LOAD is dropped and flagged; first loaded pixel uses bias[0].
        drive(1, 7, 1, 5, 0);
        drive(0, 0, 0, 0, 0);
        check("drop_err_pulse", int'(drop_err), 1);
        check("bias_loaded_partial", int'(bias_loaded), 0);
        drive(0, 0, 1, -3, 0);
        drive(0, 0, 0, 0, 0);
        check("drop_err_clear", int'(drop_err), 0);
        check("bias_loaded_full", int'(bias_loaded), 1);
        for (int i = 0; i < 128; i++) drive(1, (i < 64) ? 10 : 1, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0);

        // Saturation at both rails.
        do_reset();
        load_bias(100, -100);
        for (int i = 0; i < 128; i++) begin
            if (i < 64) drive(1, (i % 2) ? 32700 : rand16(), 0, 0, 0);
            else        drive(1, (i % 2) ? -32700 : rand16(), 0, 0, 0);
        end

        // Stride2 frame start, toggled mid-frame, then a full-size frame with stride2 noise.
        for (int i = 0; i < 32; i++) drive(1, rand16(), 0, 0, (i < 5));
        for (int i = 0; i < 128; i++) drive(1, rand16(), 0, 0, (i == 0) ? 1'b0 : 1'($urandom));
        repeat (3) drive(0, 0, 0, 0, 0);

        // Reset at pixel 30 of ch1, then reload and random back-to-back frames with gaps.
        for (int i = 0; i < 94; i++) drive(1, rand16(), 0, 0, 0);
        do_reset();
        repeat (3) drive(0, 0, 0, 0, 0);
        check("bias_loaded_after_reset", int'(bias_loaded), 0);
        load_bias(rand16(), rand16());
        for (int i = 0; i < 700; i++) begin
            drive(($urandom_range(0, 3) != 0), rand16(), 1'($urandom), rand16(), 1'($urandom));
        end

        repeat (4) drive(0, 0, 0, 0, 0);
        check("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cnn_conv_bias_relu.md
CNN_CONV_BIAS_RELU -- requirements
Module: cnn_conv_bias_relu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed two's-complement pixel, bias and output width.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 8: input image columns.
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 8: input image rows.
REQ-004 SHALL have parameter CHANNEL_NUM_OUT, default 2: output channels produced by the upstream 1x1 conv.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port valid_in, input, 1: qualifies pxl_in.
REQ-008 SHALL have port pxl_in, input, DATA_WIDTH: conv output pixel; channel-major order (all pixels of ch0, then ch1, ...).
REQ-009 SHALL have port valid_bias_in, input, 1: qualifies bias_in.
REQ-010 SHALL have port bias_in, input, DATA_WIDTH: per-channel bias, ch0 first.
REQ-011 SHALL have port stride2, input, 1: 1 means pixels per channel = IMAGE_SIZE/4.
REQ-012 SHALL have port pxl_out, output, DATA_WIDTH: biased (and rectified) pixel.
REQ-013 SHALL have port valid_out, output, 1: qualifies pxl_out.
REQ-014 SHALL have port bias_loaded, output, 1: high once all CHANNEL_NUM_OUT biases are stored.
REQ-015 SHALL have port drop_err, output, 1: one-cycle pulse when valid_in arrives before biases are loaded.

Function
REQ-016 SHALL implement FSM states LOAD and RUN; reset enters LOAD.
REQ-017 In LOAD, each valid_bias_in cycle SHALL write bias_in to bias[bias_cnt], then increment bias_cnt; after entry CHANNEL_NUM_OUT-1 SHALL go to RUN and set bias_loaded the next cycle.
REQ-018 In RUN, valid_bias_in SHALL be ignored; biases SHALL persist until reset.
REQ-019 In LOAD, valid_in SHALL be dropped (no valid_out) and SHALL pulse drop_err the next cycle; the pixel/channel counters SHALL not move.
REQ-020 Per-channel pixel count N SHALL be IMAGE_WIDTH*IMAGE_HEIGHT, or that value divided by 4 when stride2=1; stride2 SHALL be sampled only on the first pixel of channel 0 (pix_cnt=0, ch_cnt=0) and held for the whole frame.
REQ-021 Each accepted pixel SHALL use bias[ch_cnt]; pix_cnt SHALL increment per pixel, wrap at N-1 to 0 and advance ch_cnt; ch_cnt SHALL wrap at CHANNEL_NUM_OUT-1 to 0 (next frame), with no idle cycle needed.
REQ-022 Sum SHALL be computed at DATA_WIDTH+1 bits and saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-023 Latency SHALL be exactly 2 cycles valid_in to valid_out (stage 1: add; stage 2: saturate/ReLU); throughput one pixel per cycle; valid_in gaps SHALL propagate as valid_out gaps with no reordering.
REQ-024 The block SHALL apply no backpressure; a pixel on every cycle SHALL be accepted.

Reset
REQ-025 On reset: pxl_out=0, valid_out=0, bias_loaded=0, drop_err=0, pix_cnt=0, ch_cnt=0, bias_cnt=0, state=LOAD, pipeline valids cleared.
REQ-026 Reset mid-frame SHALL discard in-flight pixels (no valid_out on the following cycles) and SHALL require a full bias reload.
REQ-027 Bias storage contents need not be cleared by reset; they SHALL be unused until reloaded.

Configuration
REQ-028 With macro CNN_CONV_BIAS_RELU_EN defined, stage 2 SHALL output 0 for any negative saturated sum; without it, the saturated sum SHALL pass unchanged; latency identical in both builds.

Structure
REQ-029 The shared conv parameter package/include SHALL hold IMAGE_SIZE, the FSM state encoding, and counter widths ($clog2 of N and CHANNEL_NUM_OUT).
REQ-030 One sub-module, cnn_sat_add (signed add + saturation, combinational), SHALL be used; everything else is inline.

Verification
REQ-031 Load biases {5,-3}; stream 64 pixels of 10 then 64 of 1 (stride2=0) -> 64 outputs 15 then 64 outputs 0 (ReLU on) / -2 (ReLU off), each 2 cycles after input.
REQ-032 DATA_WIDTH=16, bias 100, pixel 32700 -> pxl_out 32767; bias -100, pixel -32700, ReLU off -> -32768.
REQ-033 stride2=1 at frame start, toggled mid-frame -> channel switches after 16 pixels; toggle ignored until the next frame.
REQ-034 valid_in asserted before the 2nd bias -> drop_err pulses, no valid_out; after loading, first pixel uses bias[0].
REQ-035 Reset asserted at pixel 30 of ch1 -> valid_out 0 on the following cycles, bias_loaded 0; after reload, counting restarts at ch0 pix0.
REQ-036 Back-to-back frames with random valid_in gaps -> output stream equals scoreboard model, ch_cnt wraps to 0 with no lost pixel.
